// File: rtl/dota_pkg.sv
// Shared types and constants for the digital-OTA comparator decimator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state type, window length table indexed by win_sel, default result width.
package dota_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DUMP  = 2'd2
   } dota_state_t;

   localparam int RES_W_DEF = 8;

   // Window lengths for win_sel = 0..3 (element [0] is the rightmost).
   localparam logic [3:0][8:0] WIN_LEN_TBL = {9'd256, 9'd128, 9'd64, 9'd32};

   // Sample-counter value reached on the last cycle of a window (N-1).
   function automatic logic [7:0] win_last(input logic [1:0] sel);
      logic [8:0] n;
      n = WIN_LEN_TBL[sel];
      return 8'(n - 9'd1);
   endfunction

endpackage

// File: rtl/dota_cmp_cond.sv
// Conditions the asynchronous comparator bit into a clean clk-domain sample.
// Latency: SYNC_STAGES cycles; one more cycle when DOTA_DEGLITCH_EN is defined.
// Backpressure: none, produces one sample every cycle.
// Ports: clk, rst_n (async active-low), cmp_i (async comparator bit), s_o (conditioned sample).
// Build option: DOTA_DEGLITCH_EN adds a registered 3-sample majority vote that drops one-cycle glitches.
module dota_cmp_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cmp_i,
   output logic s_o
);

   // A single flop is not a synchronizer; anything below 2 is built as 2.
   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [NS-1:0] sync_q;
   logic          sync_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NS-2:0], cmp_i};
      end
   end

   assign sync_out = sync_q[NS-1];

`ifdef DOTA_DEGLITCH_EN
   logic [1:0] hist_q;
   logic       maj_q;
   logic       maj_d;

   // Majority of the newest synchronized sample and the two before it.
   always_comb begin
      maj_d = (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         maj_q  <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], sync_out};
         maj_q  <= maj_d;
      end
   end

   assign s_o = maj_q;
`else
   assign s_o = sync_out;
`endif

endmodule

// File: rtl/dota_decimator.sv
// Counts comparator ones over a window of N = 32/64/128/256 samples and reports a saturated result.
// Latency: result and valid appear in the cycle after the Nth sample; one result every N+1 cycles.
// Backpressure: none, valid is a one-cycle pulse that must be captured when it occurs.
// Ports: clk, rst_n (async active-low), cmp_in (async comparator bit), en (run/abort), win_sel (window
//   select), result (ones count), valid (new-result pulse), sat (result clipped), busy (ACCUM or DUMP),
//   cmp_sync (conditioned sample, debug).
// Build option: DOTA_DEGLITCH_EN enables the majority glitch filter inside dota_cmp_cond.
module dota_decimator
   import dota_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RES_W       = RES_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmp_in,
   input  logic             en,
   input  logic [1:0]       win_sel,
   output logic [RES_W-1:0] result,
   output logic             valid,
   output logic             sat,
   output logic             busy,
   output logic             cmp_sync
);

   localparam logic [RES_W:0] RES_MAX = {1'b0, {RES_W{1'b1}}};
   localparam logic [RES_W:0] ACC_MAX = '1;

   dota_state_t      state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [RES_W:0]   acc_q, acc_d;
   logic [1:0]       win_q, win_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             sat_q, sat_d;

   logic             s;
   logic [RES_W:0]   acc_inc;
   logic             last;

   dota_cmp_cond #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cmp_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .cmp_i (cmp_in),
      .s_o   (s)
   );

   // One extra bit lets a full 256-sample window reach 256 before clipping; the add
   // still sticks at all-ones so small RES_W values cannot wrap back to a low count.
   assign acc_inc = (acc_q == ACC_MAX) ? acc_q : acc_q + (RES_W+1)'(s);
   assign last    = (cnt_q == win_last(win_q));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      win_d    = win_q;
      result_d = result_q;
      sat_d    = sat_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            acc_d = '0;
            if (en) begin
               state_d = ST_ACCUM;
               win_d   = win_sel;
            end
         end
         ST_ACCUM: begin
            if (!en) begin
               // Abort: window discarded, published result left untouched.
               state_d = ST_IDLE;
               cnt_d   = '0;
               acc_d   = '0;
            end else if (last) begin
               state_d = ST_DUMP;
               cnt_d   = '0;
               acc_d   = '0;
               if (acc_inc > RES_MAX) begin
                  result_d = RES_MAX[RES_W-1:0];
                  sat_d    = 1'b1;
               end else begin
                  result_d = acc_inc[RES_W-1:0];
                  sat_d    = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               acc_d = acc_inc;
            end
         end
         ST_DUMP: begin
            // The sample arriving during DUMP is dropped.
            cnt_d   = '0;
            acc_d   = '0;
            win_d   = win_sel;
            state_d = en ? ST_ACCUM : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         win_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         win_q    <= win_d;
         result_q <= result_d;
         sat_q    <= sat_d;
      end
   end

   assign result   = result_q;
   assign sat      = sat_q;
   assign valid    = (state_q == ST_DUMP);
   assign busy     = (state_q != ST_IDLE);
   assign cmp_sync = s;

endmodule

// File: tb/tb_dota_decimator.sv
// Self-checking bench for dota_decimator: directed scenarios plus a random phase, all checked
// against a window-level reference model built from per-edge comparator history.
// Summary line: CHECKS <n> ERRORS <n>.
module tb_dota_decimator;

   localparam int SS   = 2;
   localparam int RW   = 8;
   localparam int MAXC = 8192;
   localparam int RMAX = (1 << RW) - 1;
`ifdef DOTA_DEGLITCH_EN
   localparam int EXP_PULSE = 0;
`else
   localparam int EXP_PULSE = 4;
`endif

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b1;
   logic          cmp_in  = 1'b0;
   logic          en      = 1'b0;
   logic [1:0]    win_sel = 2'd0;
   logic [RW-1:0] result;
   logic          valid;
   logic          sat;
   logic          busy;
   logic          cmp_sync;

   int checks = 0;
   int errors = 0;

   dota_decimator #(
      .SYNC_STAGES (SS),
      .RES_W       (RW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmp_in   (cmp_in),
      .en       (en),
      .win_sel  (win_sel),
      .result   (result),
      .valid    (valid),
      .sat      (sat),
      .busy     (busy),
      .cmp_sync (cmp_sync)
   );

   always #5 clk = ~clk;

   // Reference state: comparator value seen at each edge, and the current window as start edge + length.
   bit hist [MAXC];
   int cyc       = 0;
   bit m_act     = 1'b0;
   int m_start   = 0;
   int m_n       = 0;
   int m_res     = 0;
   bit m_sat     = 1'b0;
   bit m_valid   = 1'b0;
   int stim_mode = 0;   // 0 hold cmp_in, 1 one-cycle pulse every 8, 2 random

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int win_n(input logic [1:0] sel);
      return 32 << sel;
   endfunction

   function automatic bit cmp_at(input int idx);
      if (idx < 1 || idx >= MAXC) return 1'b0;
      return hist[idx];
   endfunction

   // Sample bit consumed by the accumulator at edge e.
   function automatic bit s_at(input int e);
`ifdef DOTA_DEGLITCH_EN
      int ones;
      ones = int'(cmp_at(e-1-SS)) + int'(cmp_at(e-2-SS)) + int'(cmp_at(e-3-SS));
      return ones >= 2;
`else
      return cmp_at(e - SS);
`endif
   endfunction

   // Window bookkeeping at edge 'cyc': edges m_start+1..m_start+m_n close sample cycles,
   // the following edge closes the dump cycle.
   task automatic model_edge();
      m_valid = 1'b0;
      if (!m_act) begin
         if (en) begin
            m_act   = 1'b1;
            m_start = cyc;
            m_n     = win_n(win_sel);
         end
      end else if (cyc <= m_start + m_n) begin
         if (!en) begin
            m_act = 1'b0;
         end else if (cyc == m_start + m_n) begin
            int sum = 0;
            for (int e = m_start + 1; e <= cyc; e++) sum += int'(s_at(e));
            m_sat   = (sum > RMAX);
            m_res   = m_sat ? RMAX : sum;
            m_valid = 1'b1;
         end
      end else begin
         if (en) begin
            m_start = cyc;
            m_n     = win_n(win_sel);
         end else begin
            m_act = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
         errors++;
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $fatal(1, "cycle budget exhausted");
      end
      hist[cyc] = rst_n ? cmp_in : 1'b0;
      if (!rst_n) begin
         m_act   = 1'b0;
         m_res   = 0;
         m_sat   = 1'b0;
         m_valid = 1'b0;
      end else begin
         model_edge();
      end
      #1;
      chk("valid", valid, m_valid);
      chk("busy", busy, m_act);
      chk("result", result, m_res);
      chk("sat", sat, m_sat);
      chk("cmp_sync", cmp_sync, s_at(cyc + 1));
      case (stim_mode)
         1:       cmp_in = ((cyc + 1) % 8 == 0);
         2:       cmp_in = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic wait_valid(input string tag, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (valid === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      int t0, v1, v2, v3, saved;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_result", result, 0);
      chk("rst_valid", valid, 0);
      chk("rst_sat", sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmp_sync", cmp_sync, 0);
      repeat (3) tick();
      #2 rst_n = 1'b1;

      // All ones, 32-sample windows
      cmp_in = 1'b1;
      repeat (6) tick();
      win_sel = 2'd0;
      en      = 1'b1;
      tick();
      t0 = cyc;
      wait_valid("s1_v1", 40, v1);
      chk("s1_first_valid_cycle", v1 - t0 + 1, 33);
      chk("s1_result", result, 32);
      chk("s1_sat", sat, 0);
      wait_valid("s1_v2", 40, v2);
      chk("s1_period_a", v2 - v1, 33);
      wait_valid("s1_v3", 40, v3);
      chk("s1_period_b", v3 - v2, 33);
      chk("s1_result_3", result, 32);

      // All ones over 256 samples saturates, then zeros flush through
      en = 1'b0;
      repeat (3) tick();
      win_sel = 2'd3;
      en      = 1'b1;
      tick();
      wait_valid("s2_v1", 300, v1);
      chk("s2_sat_result", result, 255);
      chk("s2_sat_flag", sat, 1);
      cmp_in = 1'b0;
      wait_valid("s2_v2", 300, v2);
      wait_valid("s2_v3", 300, v3);
      chk("s2_zero_result", result, 0);
      chk("s2_zero_sat", sat, 0);

      // Isolated one-cycle pulses
      en = 1'b0;
      repeat (3) tick();
      win_sel   = 2'd0;
      stim_mode = 1;
      repeat (16) tick();
      en = 1'b1;
      tick();
      wait_valid("s3_v1", 40, v1);
      wait_valid("s3_v2", 40, v2);
      chk("s3_pulse_result", result, EXP_PULSE);
      chk("s3_pulse_period", v2 - v1, 33);

      // Abort at sample cycle 20 of 64
      en = 1'b0;
      stim_mode = 2;
      repeat (3) tick();
      win_sel = 2'd1;
      en      = 1'b1;
      tick();
      repeat (19) tick();
      saved = m_res;
      en    = 1'b0;
      tick();
      chk("s4_abort_busy", busy, 0);
      chk("s4_abort_valid", valid, 0);
      chk("s4_abort_result", result, saved);
      repeat (70) tick();

      // win_sel change mid-window takes effect at the next latch point
      win_sel = 2'd0;
      en      = 1'b1;
      tick();
      t0 = cyc;
      repeat (10) tick();
      win_sel = 2'd2;
      wait_valid("s5_v1", 40, v1);
      chk("s5_first_period", v1 - t0 + 1, 33);
      wait_valid("s5_v2", 140, v2);
      chk("s5_second_period", v2 - v1, 129);

      // Asynchronous reset in the middle of a window
      en = 1'b0;
      repeat (3) tick();
      win_sel = 2'd0;
      en      = 1'b1;
      tick();
      repeat (10) tick();
      #2 rst_n = 1'b0;
      for (int i = 0; i < 8; i++) if (cyc - i >= 0) hist[cyc - i] = 1'b0;
      #1;
      chk("s6_rst_result", result, 0);
      chk("s6_rst_valid", valid, 0);
      chk("s6_rst_sat", sat, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_cmp_sync", cmp_sync, 0);
      m_act = 1'b0;
      m_res = 0;
      m_sat = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b1;
      tick();
      t0 = cyc;
      wait_valid("s6_v1", 40, v1);
      chk("s6_first_valid_cycle", v1 - t0 + 1, 33);

      // Random en / win_sel / cmp_in
      repeat (1500) begin
         if ($urandom_range(0, 99) < 2) en = ~en;
         if ($urandom_range(0, 99) < 3) win_sel = 2'($urandom_range(0, 3));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dota_decimator.md
DOTA_DECIMATOR -- requirements
Module: dota_decimator

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the cmp_in synchronizer (minimum 2).
REQ-002 Parameter RES_W, default 8, width of the result output.
REQ-003 Port clk, input, 1, the single clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port cmp_in, input, 1, asynchronous 1-bit output of the digital OTA comparator.
REQ-006 Port en, input, 1, run enable; low aborts and idles.
REQ-007 Port win_sel, input, 2, window length select: N = 32, 64, 128 or 256 for win_sel 0 to 3.
REQ-008 Port result, output, RES_W, count of ones in the last completed window.
REQ-009 Port valid, output, 1, single-cycle pulse marking a new result.
REQ-010 Port sat, output, 1, the current result was clipped to 2^RES_W-1.
REQ-011 Port busy, output, 1, high while in ACCUM or DUMP.
REQ-012 Port cmp_sync, output, 1, conditioned comparator bit, for debug.

Function
REQ-013 cmp_in SHALL pass through a SYNC_STAGES flop synchronizer; its output, optionally filtered (REQ-026), SHALL be the sample bit s.
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DUMP.
REQ-015 IDLE: the sample counter and accumulator are held at 0; IDLE goes to ACCUM on the first edge where en=1, and win_sel is latched on that same edge.
REQ-016 ACCUM: each cycle, the sample counter increments and the accumulator adds s; the window is exactly N ACCUM cycles, and the Nth cycle's s is included.
REQ-017 On the edge ending the Nth ACCUM cycle: the FSM goes to DUMP, result takes min(acc+s, 2^RES_W-1), and sat is set if clipping occurred.
REQ-018 DUMP lasts one cycle with valid=1, and s is discarded in that cycle.
REQ-019 DUMP clears the counters and re-latches win_sel; it then goes to ACCUM if en=1, otherwise to IDLE.
REQ-020 Consequences: the result period is N+1 cycles, and the first valid comes N+1 cycles after the IDLE->ACCUM edge.
REQ-021 The accumulator SHALL be RES_W+1 bits wide so that N=256 with all ones yields 256 before saturation.
REQ-022 en=0 during ACCUM SHALL abort: go to IDLE on the next edge, clear the counters, give no valid, and leave result and sat unchanged.
REQ-023 en=0 in the DUMP cycle SHALL still complete the DUMP (valid=1), then go to IDLE.
REQ-024 A change of win_sel during ACCUM SHALL have no effect until the next latch point.

Reset
REQ-025 While rst_n=0, all state SHALL be cleared asynchronously: FSM=IDLE, synchronizer and filter flops=0, result=0, valid=0, sat=0, busy=0, cmp_sync=0; reset asserted mid-window discards that window.

Configuration
REQ-026 With DOTA_DEGLITCH_EN defined, s SHALL be the registered majority of the last 3 synchronized samples (latency +1 cycle, single-cycle glitches rejected); without it, s SHALL be the synchronizer output directly.

Structure
REQ-027 The shared package dota_pkg SHALL hold the FSM state typedef, the window length table (32/64/128/256) and the RES_W default.
REQ-028 The synchronizer and optional filter SHALL form one sub-module, dota_cmp_cond; the FSM and accumulator stay in dota_decimator.

Verification
REQ-029 The bench SHALL cover: cmp_in=1 constant, win_sel=0, en=1 -> valid every 33 cycles, result=32, sat=0.
REQ-030 The bench SHALL cover: cmp_in=1 constant, win_sel=3 -> result=255, sat=1; then cmp_in=0 -> next-but-one result=0, sat=0.
REQ-031 The bench SHALL cover: cmp_in=0 with a one-cycle 1 pulse every 8 cycles, win_sel=0 -> result=4 without DOTA_DEGLITCH_EN and result=0 with it.
REQ-032 The bench SHALL cover: en dropped at ACCUM cycle 20 of 64 -> IDLE next cycle, no valid, result holds the prior value, busy=0.
REQ-033 The bench SHALL cover: win_sel changed 0->2 mid-window -> the current window still gives a 33-cycle period, and the next window is 128 samples (129-cycle period).
REQ-034 The bench SHALL cover: rst_n pulsed low mid-ACCUM -> all outputs 0 immediately; after release with en=1, the first valid comes N+1 cycles after the IDLE->ACCUM edge.
